// File: rtl/clkdiv_bank.sv
// ---------------------------------------------------------------------------
// clkdiv_bank
//
// A bank of NCH independent clock dividers that share one clock. Each channel
// counts clk cycles and toggles its divided clock every eff cycles, where eff
// is the channel's active divisor (a divisor of 0 counts as 1). The output
// period is therefore 2*eff cycles with a 50% duty cycle. A one-cycle tick
// accompanies every toggle.
//
// Divisors are loaded through a valid/ready port. A load to a running channel
// is held in a shadow register and takes effect at that channel's next
// terminal count, so a half-period is never cut short or stretched mid-way.
// A load to a stopped channel, or one that lands on a sync edge, is written
// straight into the active divisor.
//
// Ports
//   clk        in   1            sole clock, rising edge
//   rst_n      in   1            asynchronous active-low reset
//   en         in   NCH          per-channel run enable
//   sync       in   1            restart the phase of every channel
//   cfg_valid  in   1            divisor-load request
//   cfg_ready  out  1            addressed channel can take a load (comb.)
//   cfg_ch     in   CHW          target channel of the load
//   cfg_div    in   WIDTH        new divisor, unsigned
//   clk_div    out  NCH          registered divided clocks
//   tick       out  NCH          registered one-cycle pulse on each toggle
// ---------------------------------------------------------------------------
module clkdiv_bank #(
   parameter int NCH     = 4,
   parameter int WIDTH   = 32,
   parameter int DEF_DIV = 1,
   localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NCH-1:0]   en,
   input  logic             sync,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CHW-1:0]   cfg_ch,
   input  logic [WIDTH-1:0] cfg_div,
   output logic [NCH-1:0]   clk_div,
   output logic [NCH-1:0]   tick
);

   // ------------------------------------------------------------------------
   // Per-channel state
   // ------------------------------------------------------------------------
   logic [WIDTH-1:0] cnt_q [NCH];
   logic [WIDTH-1:0] cnt_d [NCH];
   logic [WIDTH-1:0] act_q [NCH];
   logic [WIDTH-1:0] act_d [NCH];
   logic [WIDTH-1:0] shd_q [NCH];
   logic [WIDTH-1:0] shd_d [NCH];
   logic [NCH-1:0]   pend_q;
   logic [NCH-1:0]   pend_d;
   logic [NCH-1:0]   clk_div_q;
   logic [NCH-1:0]   clk_div_d;
   logic [NCH-1:0]   tick_q;
   logic [NCH-1:0]   tick_d;

   // Decoded helpers
   logic [WIDTH-1:0] eff_m1 [NCH];   // effective divisor minus one
   logic [NCH-1:0]   term;           // terminal count this cycle
   logic [NCH-1:0]   acc;            // load accepted into this channel

   // ------------------------------------------------------------------------
   // Load handshake.
   // A transfer happens on a rising edge where cfg_valid and cfg_ready are
   // both high. The requester holds cfg_ch/cfg_div stable while cfg_valid is
   // high and not yet accepted. cfg_ready is low only while the addressed
   // channel still holds an unapplied shadow divisor; an index beyond the
   // last channel is always ready and the transfer is simply dropped.
   // ------------------------------------------------------------------------
   always_comb begin
      cfg_ready = 1'b1;
      for (int i = 0; i < NCH; i++) begin
         if (cfg_ch == CHW'(i)) begin
            cfg_ready = ~pend_q[i];
         end
      end
   end

   always_comb begin
      acc = '0;
      for (int i = 0; i < NCH; i++) begin
         acc[i] = cfg_valid && cfg_ready && (cfg_ch == CHW'(i));
      end
   end

   // ------------------------------------------------------------------------
   // Terminal-count detection. act==0 behaves as divisor 1, so eff-1 is 0 in
   // both cases; otherwise act-1 cannot underflow. Using >= rather than ==
   // means a shrinking divisor can never leave the counter stranded above
   // its new limit.
   // ------------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         eff_m1[i] = '0;
         if (act_q[i] != '0) begin
            eff_m1[i] = act_q[i] - WIDTH'(1);
         end
         term[i] = en[i] && (cnt_q[i] >= eff_m1[i]);
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic.
   // Priority per channel: sync, then enabled run, then stopped.
   // Because acc implies pend_q==0 for that channel, an accept never collides
   // with a shadow-to-active transfer in the same cycle.
   // ------------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         cnt_d[i]     = cnt_q[i];
         act_d[i]     = act_q[i];
         shd_d[i]     = shd_q[i];
         pend_d[i]    = pend_q[i];
         clk_div_d[i] = clk_div_q[i];
         tick_d[i]    = 1'b0;

         if (sync) begin
            // Phase restart: every channel starts a fresh low half-period.
            cnt_d[i]     = '0;
            clk_div_d[i] = 1'b0;
            pend_d[i]    = 1'b0;
            if (pend_q[i]) begin
               act_d[i] = shd_q[i];
            end
            if (acc[i]) begin
               act_d[i] = cfg_div;
            end
         end else if (en[i]) begin
            if (term[i]) begin
               // This terminal ends a half-period timed by the old act; a
               // pending shadow governs the half-period that starts now.
               cnt_d[i]     = '0;
               clk_div_d[i] = ~clk_div_q[i];
               tick_d[i]    = 1'b1;
               if (pend_q[i]) begin
                  act_d[i]  = shd_q[i];
                  pend_d[i] = 1'b0;
               end
            end else begin
               cnt_d[i] = cnt_q[i] + WIDTH'(1);
            end
            // A load landing on a terminal edge is parked in the shadow and
            // waits for the following terminal.
            if (acc[i]) begin
               shd_d[i]  = cfg_div;
               pend_d[i] = 1'b1;
            end
         end else begin
            // Stopped: hold phase, but flush any parked divisor so the
            // channel restarts with the most recent setting.
            if (pend_q[i]) begin
               act_d[i]  = shd_q[i];
               pend_d[i] = 1'b0;
            end
            if (acc[i]) begin
               act_d[i] = cfg_div;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= '0;
            act_q[i] <= WIDTH'(DEF_DIV);
            shd_q[i] <= '0;
         end
         pend_q    <= '0;
         clk_div_q <= '0;
         tick_q    <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= cnt_d[i];
            act_q[i] <= act_d[i];
            shd_q[i] <= shd_d[i];
         end
         pend_q    <= pend_d;
         clk_div_q <= clk_div_d;
         tick_q    <= tick_d;
      end
   end

   assign clk_div = clk_div_q;
   assign tick    = tick_q;

endmodule
